// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential integer square root, one result bit per clock.
// Restoring digit recurrence, MSB first. The result is ready WIDTH/2 clocks
// after the operand is accepted. A new operand can be accepted in the cycle
// that presents the result.
// Optional build macro ISQRT_ROUND_EN: when defined, dout is rounded to the
// nearest integer instead of truncated. It saturates at the all-ones root.
// rem always reports din - floor(sqrt(din))^2.
module isqrt_seq #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_rdy,
    input  logic [WIDTH-1:0]         din,
    output logic                     busy,
    output logic [WIDTH/32'sd2-1:0]  dout,
    output logic [WIDTH/32'sd2:0]    rem,
    output logic                     dout_rdy
);

    localparam int HALF = WIDTH / 32'sd2;
    localparam int PW   = HALF + 32'sd2;
    localparam int CW   = $clog2(HALF) + 32'sd1;

    localparam logic [CW-1:0]   LAST_CNT = CW'(HALF - 32'sd1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [HALF-1:0] ROOT_ONE = {{(HALF-1){1'b0}}, 1'b1};
    localparam logic [HALF-1:0] ROOT_MAX = {HALF{1'b1}};

    // Reject odd or too-narrow operand widths at elaboration
    generate
        if (((WIDTH % 32'sd2) != 32'sd0) || (WIDTH < 32'sd4)) begin : g_bad_width
            $error("isqrt_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              accept_s;
    logic              last_s;

    logic [WIDTH-1:0]  opnd_r;
    logic [HALF-1:0]   root_r;
    logic [PW-1:0]     prem_r;
    logic [CW-1:0]     cnt_r;
    logic [HALF-1:0]   dout_r;
    logic [HALF:0]     rem_r;
    logic              busy_r;
    logic              dout_rdy_r;

    logic [PW-1:0]     r2_s;
    logic [PW-1:0]     trial_s;
    logic [PW-1:0]     prem_nxt_s;
    logic [HALF-1:0]   root_nxt_s;
    logic [HALF-1:0]   dout_fin_s;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: accept in IDLE or DONE, finish after WIDTH/2 iterations
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (din_rdy) begin
                    state_s  = ITER;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            ITER: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = ITER;
                end
            end
            DONE: begin
                if (din_rdy) begin
                    state_s  = ITER;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One restoring recurrence step: bring down two operand bits, try to subtract
    always_comb begin
        r2_s    = (prem_r << 2) | {{HALF{1'b0}}, opnd_r[WIDTH-1 -: 2]};
        trial_s = {root_r, 2'b01};
        if (r2_s >= trial_s) begin
            prem_nxt_s = r2_s - trial_s;
            root_nxt_s = {root_r[HALF-2:0], 1'b1};
        end else begin
            prem_nxt_s = r2_s;
            root_nxt_s = {root_r[HALF-2:0], 1'b0};
        end
    end

`ifdef ISQRT_ROUND_EN
    // Round to nearest: sqrt >= root+0.5 exactly when remainder > root
    always_comb begin
        if ((prem_nxt_s > {2'b00, root_nxt_s}) && (root_nxt_s != ROOT_MAX)) begin
            dout_fin_s = root_nxt_s + ROOT_ONE;
        end else begin
            dout_fin_s = root_nxt_s;
        end
    end
`else
    // Truncated root is the recurrence result as-is
    always_comb begin
        dout_fin_s = root_nxt_s;
    end
`endif

    // Datapath and output registers; results hold until the next completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opnd_r     <= '0;
            root_r     <= '0;
            prem_r     <= '0;
            cnt_r      <= '0;
            dout_r     <= '0;
            rem_r      <= '0;
            busy_r     <= 1'b0;
            dout_rdy_r <= 1'b0;
        end else begin
            busy_r     <= (state_s == ITER);
            dout_rdy_r <= last_s;
            if (accept_s) begin
                opnd_r <= din;
                root_r <= '0;
                prem_r <= '0;
                cnt_r  <= '0;
            end else if (state_r == ITER) begin
                opnd_r <= {opnd_r[WIDTH-3:0], 2'b00};
                root_r <= root_nxt_s;
                prem_r <= prem_nxt_s;
                cnt_r  <= cnt_r + CNT_ONE;
            end
            if (last_s) begin
                dout_r <= dout_fin_s;
                rem_r  <= prem_nxt_s[HALF:0];
            end
        end
    end

    assign busy     = busy_r;
    assign dout     = dout_r;
    assign rem      = rem_r;
    assign dout_rdy = dout_rdy_r;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: a 32-bit and an 8-bit instance.
// Expected values come from a table of hand-computed results and from a
// binary-search square root model.
module tb_isqrt_seq;

    localparam int W  = 32;
    localparam int H  = 16;
    localparam int W8 = 8;
    localparam int H8 = 4;
`ifdef ISQRT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         din_rdy;
    logic [W-1:0] din;
    logic         busy;
    logic [H-1:0] dout;
    logic [H:0]   rem;
    logic         dout_rdy;

    logic          b_din_rdy;
    logic [W8-1:0] b_din;
    logic          b_busy;
    logic [H8-1:0] b_dout;
    logic [H8:0]   b_rem;
    logic          b_dout_rdy;

    isqrt_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din_rdy(din_rdy), .din(din),
        .busy(busy), .dout(dout), .rem(rem), .dout_rdy(dout_rdy)
    );

    isqrt_seq #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .din_rdy(b_din_rdy), .din(b_din),
        .busy(b_busy), .dout(b_dout), .rem(b_rem), .dout_rdy(b_dout_rdy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= n, found by binary search
    function automatic void ref_model(input longint n, input int w,
                                      output longint r, output longint m, output longint d);
        longint lo = 0;
        longint hi = (longint'(1) <<< (w / 2)) - 1;
        longint mx = hi;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        r = lo;
        m = n - r * r;
        d = r;
        if (RND && (m > r)) d = (r == mx) ? mx : r + 1;
    endfunction

    // Run one 32-bit operation; optionally pulse din_rdy mid-operation
    task automatic op32(input logic [W-1:0] val, input bit poke,
                        output logic [H-1:0] d, output logic [H:0] m,
                        output int lat, output int bcnt);
        @(negedge clk);
        din = val;
        din_rdy = 1'b1;
        @(posedge clk);
        #1;
        din_rdy = 1'b0;
        din = $urandom;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!dout_rdy && lat < 100) begin
            if (poke) din_rdy = (lat == 5);
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        din_rdy = 1'b0;
        d = dout;
        m = rem;
    endtask

    task automatic op8(input logic [W8-1:0] val,
                       output logic [H8-1:0] d, output logic [H8:0] m, output int lat);
        @(negedge clk);
        b_din = val;
        b_din_rdy = 1'b1;
        @(posedge clk);
        #1;
        b_din_rdy = 1'b0;
        b_din = 8'($urandom);
        lat = 0;
        while (!b_dout_rdy && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = b_dout;
        m = b_rem;
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [H-1:0] d;
        logic [H:0]   m;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [H-1:0]  d;
        logic [H:0]    m;
        logic [H8-1:0] d8;
        logic [H8:0]   m8;
        int lat, bcnt, seen;
        longint er, em, ed;
        logic [W-1:0] v;

        tbl[0]  = '{32'd0,          16'd0,                  17'd0};
        tbl[1]  = '{32'd1,          16'd1,                  17'd0};
        tbl[2]  = '{32'd2,          16'd1,                  17'd1};
        tbl[3]  = '{32'd3,          RND ? 16'd2 : 16'd1,    17'd2};
        tbl[4]  = '{32'd16,         16'd4,                  17'd0};
        tbl[5]  = '{32'd17,         16'd4,                  17'd1};
        tbl[6]  = '{32'd20,         16'd4,                  17'd4};
        tbl[7]  = '{32'd24,         RND ? 16'd5 : 16'd4,    17'd8};
        tbl[8]  = '{32'd99,         RND ? 16'd10 : 16'd9,   17'd18};
        tbl[9]  = '{32'd1000,       RND ? 16'd32 : 16'd31,  17'd39};
        tbl[10] = '{32'h4000_0000,  16'd32768,              17'd0};
        tbl[11] = '{32'hFFFF_FFFF,  16'd65535,              17'd131070};
        tbl[12] = '{32'hFFFE_0000,  RND ? 16'd65535 : 16'd65534, 17'd131068};

        rst = 1'b0;
        din_rdy = 1'b0;
        din = '0;
        b_din_rdy = 1'b0;
        b_din = '0;
        #2;
        check("reset_busy", busy, 0);
        check("reset_dout_rdy", dout_rdy, 0);
        check("reset_dout", dout, 0);
        check("reset_rem", rem, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed table: latency, busy length and results
        foreach (tbl[i]) begin
            op32(tbl[i].din, 1'b0, d, m, lat, bcnt);
            check($sformatf("tbl%0d_latency", i), lat, H);
            check($sformatf("tbl%0d_busy_len", i), bcnt, H);
            check($sformatf("tbl%0d_dout", i), d, tbl[i].d);
            check($sformatf("tbl%0d_rem", i), m, tbl[i].m);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_pulse_one_cycle", i), dout_rdy, 0);
        end

        // Back-to-back with din_rdy held high; operand changes while busy are ignored
        @(negedge clk);
        din = 32'd100;
        din_rdy = 1'b1;
        @(posedge clk);
        #1;
        din = 32'd144;
        lat = 0;
        while (!dout_rdy && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_latency", lat, H);
        check("b2b_first_dout", dout, 10);
        check("b2b_first_rem", rem, 0);
        @(posedge clk);
        #1;
        din = 32'd7;
        check("b2b_reaccept_busy", busy, 1);
        check("b2b_pulse_drop", dout_rdy, 0);
        check("b2b_dout_held", dout, 10);
        lat = 1;
        while (!dout_rdy && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        din_rdy = 1'b0;
        check("b2b_pulse_spacing", lat, H + 1);
        check("b2b_second_dout", dout, 12);
        check("b2b_second_rem", rem, 0);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", busy, 0);

        // Reset at iteration 7 aborts; no pulse afterwards
        @(negedge clk);
        din = 32'd1000;
        din_rdy = 1'b1;
        @(posedge clk);
        #1;
        din_rdy = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dout_rdy", dout_rdy, 0);
        check("abort_dout", dout, 0);
        check("abort_rem", rem, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (dout_rdy || busy) seen++;
        end
        check("no_spurious_activity", seen, 0);
        op32(32'd1000, 1'b0, d, m, lat, bcnt);
        check("after_reset_dout", d, RND ? 32 : 31);
        check("after_reset_rem", m, 39);

        // Random sweep on the 32-bit instance, against the reference model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 1000));
                default: begin
                    er = longint'($urandom_range(0, 65535));
                    v = 32'(er * er + longint'($urandom_range(0, 2)));
                end
            endcase
            op32(v, (i % 3) == 0, d, m, lat, bcnt);
            ref_model(longint'(v), W, er, em, ed);
            check($sformatf("rnd%0d_latency din=%0d", i, v), lat, H);
            check($sformatf("rnd%0d_dout din=%0d", i, v), d, ed);
            check($sformatf("rnd%0d_rem din=%0d", i, v), m, em);
        end

        // Exhaustive sweep on the 8-bit instance
        for (int i = 0; i < 256; i++) begin
            op8(8'(i), d8, m8, lat);
            ref_model(longint'(i), W8, er, em, ed);
            check($sformatf("w8_%0d_latency", i), lat, H8);
            check($sformatf("w8_%0d_dout", i), d8, ed);
            check($sformatf("w8_%0d_rem", i), m8, em);
        end
        op8(8'd255, d8, m8, lat);
        check("w8_allones_dout", d8, 15);
        check("w8_allones_rem", m8, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
